// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired control sequencer of the
// single-bus CPU: instruction opcodes, ALU function codes, the sequencer
// state enum and the opcode-class enum, plus the opcode-to-ALU-code helper.
package cpu_ctrl_pkg;

    // Instruction opcodes (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes share the encoding of the matching register opcodes
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    typedef enum logic [3:0] {
        RESET, F0, F1, F2, F3, E0, E1, E2, E3, E4, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_REG, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD,
        CLS_ST, CLS_BR, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_HALT
    } op_class_t;

    // Immediate forms and address/branch arithmetic reuse the register ALU codes
    function automatic logic [4:0] alu_code_for(input logic [4:0] opcode);
        logic [4:0] code;
        case (opcode)
            OP_ADDI:                     code = ALU_ADD;
            OP_ANDI:                     code = ALU_AND;
            OP_ORI:                      code = ALU_OR;
            OP_LD, OP_LDI, OP_ST, OP_BR: code = ALU_ADD;
            default:                     code = opcode;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier.
//   opcode   in  5  IR[31:27]
//   op_class out    execute-sequence class of the instruction
//   alu_code out 5  ALU function to present when the class uses the ALU
//   uses_alu out 1  class drives alu_op in one of its execute steps
module ctrl_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] alu_code,
    output logic       uses_alu
);

    // Map each opcode onto its class; unassigned opcodes fall back to nop
    always_comb begin
        op_class = CLS_NOP;
        uses_alu = 1'b0;
        alu_code = alu_code_for(opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
            OP_SHL: begin
                op_class = CLS_REG;
                uses_alu = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                op_class = CLS_IMM;
                uses_alu = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                op_class = CLS_UNARY;
                uses_alu = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                op_class = CLS_MULDIV;
                uses_alu = 1'b1;
            end
            OP_LDI: begin
                op_class = CLS_LDI;
                uses_alu = 1'b1;
            end
            OP_LD: begin
                op_class = CLS_LD;
                uses_alu = 1'b1;
            end
            OP_ST: begin
                op_class = CLS_ST;
                uses_alu = 1'b1;
            end
            OP_BR: begin
                op_class = CLS_BR;
                uses_alu = 1'b1;
            end
            OP_JR:   op_class = CLS_JR;
            OP_MFHI: op_class = CLS_MFHI;
            OP_MFLO: op_class = CLS_MFLO;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU. Steps each
// instruction through fetch F0..F3 and execute E0..E4, one step per clock.
//   clk, clear      clock and asynchronous active-low reset
//   IR              instruction register (opcode = IR[31:27])
//   CON             branch condition flag
//   mem_ready       memory finished the pending Read/Write
//   Stop            halt request, sampled only in F0
//   datapath / memory / register-select strobes, alu_op, Run  outputs
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        mem_ready,
    input  logic        Stop,
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
    output logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    output logic        Cout, CONin,
    output logic        Read, Write,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic [4:0]  alu_op,
    output logic        Run
);

    state_t     state_r;
    state_t     next_state_s;
    op_class_t  op_class_s;
    logic [4:0] alu_code_s;
    logic       uses_alu_s;
    logic       alu_sel_s;
    logic       unused_ir_bits_s;

    assign unused_ir_bits_s = ^IR[26:0];

    ctrl_op_decode u_decode (
        .opcode   (IR[31:27]),
        .op_class (op_class_s),
        .alu_code (alu_code_s),
        .uses_alu (uses_alu_s)
    );

    // State register; clear forces RESET at any time, even mid-wait
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r <= RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and strobe decode from the current step and opcode class
    always_comb begin
        next_state_s = state_r;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin} = 7'b0000000;
        {Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout} = 8'b00000000;
        {Cout, CONin, Read, Write} = 4'b0000;
        {Gra, Grb, Grc, Rin, Rout, BAout} = 6'b000000;
        alu_sel_s = 1'b0;
        Run       = 1'b1;
        case (state_r)
            RESET: begin
                Run          = 1'b0;
                next_state_s = F0;
            end
            F0: begin
                // A pending Stop suppresses this step's strobes
                if (Stop) begin
                    next_state_s = HALT;
                end else begin
                    {PCout, MARin, IncPC, Zin} = 4'b1111;
                    next_state_s = F1;
                end
            end
            F1: begin
                {Zlowout, PCin} = 2'b11;
                next_state_s    = F2;
            end
            F2: begin
                {Read, MDRin} = 2'b11;
                if (mem_ready) next_state_s = F3;
                else           next_state_s = F2;
            end
            F3: begin
                {MDRout, IRin} = 2'b11;
                case (op_class_s)
                    CLS_NOP:  next_state_s = F0;
                    CLS_HALT: next_state_s = HALT;
                    default:  next_state_s = E0;
                endcase
            end
            E0: begin
                next_state_s = E1;
                case (op_class_s)
                    CLS_REG, CLS_IMM:       {Grb, Rout, Yin} = 3'b111;
                    CLS_UNARY: begin
                        {Grb, Rout, Zin} = 3'b111;
                        alu_sel_s        = 1'b1;
                    end
                    CLS_MULDIV:             {Gra, Rout, Yin} = 3'b111;
                    CLS_LDI, CLS_LD, CLS_ST: {Grb, BAout, Yin} = 3'b111;
                    CLS_BR:                 {Gra, Rout, CONin} = 3'b111;
                    CLS_JR: begin
                        {Gra, Rout, PCin} = 3'b111;
                        next_state_s      = F0;
                    end
                    CLS_MFHI: begin
                        {HIout, Gra, Rin} = 3'b111;
                        next_state_s      = F0;
                    end
                    CLS_MFLO: begin
                        {LOout, Gra, Rin} = 3'b111;
                        next_state_s      = F0;
                    end
                    default: next_state_s = F0;
                endcase
            end
            E1: begin
                next_state_s = E2;
                case (op_class_s)
                    CLS_REG: begin
                        {Grc, Rout, Zin} = 3'b111;
                        alu_sel_s        = 1'b1;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        {Cout, Zin} = 2'b11;
                        alu_sel_s   = 1'b1;
                    end
                    CLS_UNARY: begin
                        {Zlowout, Gra, Rin} = 3'b111;
                        next_state_s        = F0;
                    end
                    CLS_MULDIV: begin
                        {Grb, Rout, Zin} = 3'b111;
                        alu_sel_s        = 1'b1;
                    end
                    CLS_BR:  {PCout, Yin} = 2'b11;
                    default: next_state_s = F0;
                endcase
            end
            E2: begin
                next_state_s = E3;
                case (op_class_s)
                    CLS_REG, CLS_IMM, CLS_LDI: begin
                        {Zlowout, Gra, Rin} = 3'b111;
                        next_state_s        = F0;
                    end
                    CLS_MULDIV:     {Zlowout, LOin} = 2'b11;
                    CLS_LD, CLS_ST: {Zlowout, MARin} = 2'b11;
                    CLS_BR: begin
                        {Cout, Zin} = 2'b11;
                        alu_sel_s   = 1'b1;
                    end
                    default: next_state_s = F0;
                endcase
            end
            E3: begin
                next_state_s = F0;
                case (op_class_s)
                    CLS_MULDIV: {Zhighout, HIin} = 2'b11;
                    CLS_LD: begin
                        {Read, MDRin} = 2'b11;
                        if (mem_ready) next_state_s = E4;
                        else           next_state_s = E3;
                    end
                    CLS_ST: begin
                        // Read low steers the bus, not memory, into MDR
                        {Gra, Rout, MDRin} = 3'b111;
                        next_state_s       = E4;
                    end
                    CLS_BR: begin
                        if (CON) {Zlowout, PCin} = 2'b11;
                        else     {Zlowout, PCin} = 2'b00;
                    end
                    default: next_state_s = F0;
                endcase
            end
            E4: begin
                next_state_s = F0;
                case (op_class_s)
                    CLS_LD: {MDRout, Gra, Rin} = 3'b111;
                    CLS_ST: begin
                        Write = 1'b1;
                        if (mem_ready) next_state_s = F0;
                        else           next_state_s = E4;
                    end
                    default: next_state_s = F0;
                endcase
            end
            HALT: begin
                Run          = 1'b0;
                next_state_s = HALT;
            end
            default: begin
                Run          = 1'b0;
                next_state_s = RESET;
            end
        endcase
        if (alu_sel_s && uses_alu_s) alu_op = alu_code_s;
        else                         alu_op = ALU_NONE;
    end

endmodule
